// File: rtl/sy_ppl_fp_wb_sched.sv
// rtl/sy_ppl_fp_wb_sched.sv - FP register-file writeback scheduler with round-robin arbiter and busy scoreboard
// Optional flopped write port: define SY_FP_WB_REG_EN.

package sy_pkg;
  localparam int DWTH = 64;
endpackage

module sy_ppl_fp_wb_sched #(
  parameter int NREQ = 3,
  parameter int DWTH = sy_pkg::DWTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 dec_fp_wb__alloc_en_i,
  input  logic [4:0]           dec_fp_wb__alloc_idx_i,
  output logic [31:0]          fp_wb_dec__busy_o,
  input  logic [NREQ-1:0]      ex_fp_wb__req_valid_i,
  output logic [NREQ-1:0]      fp_wb_ex__req_ready_o,
  input  logic [NREQ*5-1:0]    ex_fp_wb__req_idx_i,
  input  logic [NREQ*DWTH-1:0] ex_fp_wb__req_data_i,
  output logic                 fp_wb_fp_reg__rdst_en_o,
  output logic [4:0]           fp_wb_fp_reg__rdst_idx_o,
  output logic [DWTH-1:0]      fp_wb_fp_reg__rdst_data_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            xfer;
  logic [4:0]      sel_idx;
  logic [DWTH-1:0] sel_data;
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!gnt_found && ex_fp_wb__req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign xfer     = rst_i & ~flush_i & gnt_found;
  assign sel_idx  = ex_fp_wb__req_idx_i[int'(gnt_idx)*5 +: 5];
  assign sel_data = ex_fp_wb__req_data_i[int'(gnt_idx)*DWTH +: DWTH];
  assign ptr_nxt  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    fp_wb_ex__req_ready_o = '0;
    if (xfer) begin
      fp_wb_ex__req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_nxt;
    end
  end

`ifdef SY_FP_WB_REG_EN
  logic            wr_en_q;
  logic [4:0]      wr_idx_q;
  logic [DWTH-1:0] wr_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        wr_idx_q  <= sel_idx;
        wr_data_q <= sel_data;
      end
    end
  end

  // A flush landing in the write cycle cancels the already-accepted write.
  assign fp_wb_fp_reg__rdst_en_o   = wr_en_q & ~flush_i;
  assign fp_wb_fp_reg__rdst_idx_o  = wr_idx_q;
  assign fp_wb_fp_reg__rdst_data_o = wr_data_q;
`else
  assign fp_wb_fp_reg__rdst_en_o   = xfer;
  assign fp_wb_fp_reg__rdst_idx_o  = xfer ? sel_idx : 5'd0;
  assign fp_wb_fp_reg__rdst_data_o = xfer ? sel_data : '0;
`endif

  // Clear before set so a same-cycle alloc of the written index stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (fp_wb_fp_reg__rdst_en_o) begin
      busy_nxt[fp_wb_fp_reg__rdst_idx_o] = 1'b0;
    end
    if (dec_fp_wb__alloc_en_i) begin
      busy_nxt[dec_fp_wb__alloc_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign fp_wb_dec__busy_o = busy_q;

endmodule

// File: tb/tb_sy_ppl_fp_wb_sched.sv
// tb/tb_sy_ppl_fp_wb_sched.sv - directed table-driven bench for sy_ppl_fp_wb_sched
// Covers both builds (SY_FP_WB_REG_EN defined or not).

module tb_sy_ppl_fp_wb_sched;

  localparam int NREQ = 3;
  localparam int DWTH = 64;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 alloc_en;
  logic [4:0]           alloc_idx;
  logic [31:0]          busy;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_idx;
  logic [NREQ*DWTH-1:0] req_data;
  logic                 rdst_en;
  logic [4:0]           rdst_idx;
  logic [DWTH-1:0]      rdst_data;

  sy_ppl_fp_wb_sched #(.NREQ(NREQ), .DWTH(DWTH)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .flush_i                   (flush),
    .dec_fp_wb__alloc_en_i     (alloc_en),
    .dec_fp_wb__alloc_idx_i    (alloc_idx),
    .fp_wb_dec__busy_o         (busy),
    .ex_fp_wb__req_valid_i     (req_valid),
    .fp_wb_ex__req_ready_o     (req_ready),
    .ex_fp_wb__req_idx_i       (req_idx),
    .ex_fp_wb__req_data_i      (req_data),
    .fp_wb_fp_reg__rdst_en_o   (rdst_en),
    .fp_wb_fp_reg__rdst_idx_o  (rdst_idx),
    .fp_wb_fp_reg__rdst_data_o (rdst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  valid;
    logic        alloc_en;
    logic [4:0]  alloc_idx;
    logic        flush;
    logic [2:0]  exp_ready;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t        tbl [14];
  logic [4:0]  tbl_idx  [3];
  logic [63:0] tbl_data [3];

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic ae, input logic [4:0] ai, input logic fl);
    req_valid = v;
    alloc_en  = ae;
    alloc_idx = ai;
    flush     = fl;
  endtask

  task automatic set_req(input int r, input logic [4:0] idx, input logic [63:0] data);
    req_idx[r*5 +: 5]       = idx;
    req_data[r*DWTH +: DWTH] = data;
  endtask

  initial begin
    logic        prev_xfer;
    logic [4:0]  last_idx;
    logic [63:0] last_data;
    logic        exp_xfer;
    int          g;
    int          cnt [3];

    n_chk = 0;
    n_fail = 0;
    tbl_idx[0] = 5'd10; tbl_data[0] = 64'h1111_0000_0000_1111;
    tbl_idx[1] = 5'd11; tbl_data[1] = 64'h2222_0000_0000_2222;
    tbl_idx[2] = 5'd12; tbl_data[2] = 64'h3333_0000_0000_3333;

    //             valid   ae    ai     fl    ready   busy
    tbl[0]  = '{3'b111, 1'b1, 5'd1, 1'b0, 3'b001, 32'h0};
    tbl[1]  = '{3'b111, 1'b1, 5'd2, 1'b0, 3'b010, 32'h2};
    tbl[2]  = '{3'b111, 1'b0, 5'd0, 1'b0, 3'b100, 32'h6};
    tbl[3]  = '{3'b111, 1'b0, 5'd0, 1'b0, 3'b001, 32'h6};
    tbl[4]  = '{3'b111, 1'b0, 5'd0, 1'b0, 3'b010, 32'h6};
    tbl[5]  = '{3'b111, 1'b0, 5'd0, 1'b0, 3'b100, 32'h6};
    tbl[6]  = '{3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 32'h6};
    tbl[7]  = '{3'b110, 1'b0, 5'd0, 1'b0, 3'b010, 32'h6};
    tbl[8]  = '{3'b011, 1'b0, 5'd0, 1'b0, 3'b001, 32'h6};
    tbl[9]  = '{3'b101, 1'b0, 5'd0, 1'b0, 3'b100, 32'h6};
    tbl[10] = '{3'b111, 1'b1, 5'd3, 1'b1, 3'b000, 32'h6};
    tbl[11] = '{3'b100, 1'b0, 5'd0, 1'b0, 3'b100, 32'h0};
    tbl[12] = '{3'b010, 1'b0, 5'd0, 1'b0, 3'b010, 32'h0};
    tbl[13] = '{3'b011, 1'b0, 5'd0, 1'b0, 3'b001, 32'h0};

    for (int r = 0; r < 3; r++) begin
      set_req(r, tbl_idx[r], tbl_data[r]);
      cnt[r] = 0;
    end

    // Reset held three cycles with every requester valid
    rst = 1'b0;
    drive(3'b111, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      #3;
      chk("reset_ready", 64'(req_ready), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_rdst_en", 64'(rdst_en), 64'h0);
    end
    step();
    rst = 1'b1;

    prev_xfer = 1'b0;
    last_idx  = 5'd0;
    last_data = 64'h0;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].valid, tbl[i].alloc_en, tbl[i].alloc_idx, tbl[i].flush);
      #3;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      g = 0;
      for (int r = 0; r < 3; r++) if (tbl[i].exp_ready[r]) g = r;
      exp_xfer = |tbl[i].exp_ready;
`ifdef SY_FP_WB_REG_EN
      chk($sformatf("v%0d_rdst_en", i), 64'(rdst_en), 64'(prev_xfer & ~tbl[i].flush));
      chk($sformatf("v%0d_rdst_idx", i), 64'(rdst_idx), 64'(last_idx));
      chk($sformatf("v%0d_rdst_data", i), rdst_data, last_data);
`else
      chk($sformatf("v%0d_rdst_en", i), 64'(rdst_en), 64'(exp_xfer));
      chk($sformatf("v%0d_rdst_idx", i), 64'(rdst_idx), exp_xfer ? 64'(tbl_idx[g]) : 64'h0);
      chk($sformatf("v%0d_rdst_data", i), rdst_data, exp_xfer ? tbl_data[g] : 64'h0);
`endif
      if (exp_xfer) begin
        last_idx  = tbl_idx[g];
        last_data = tbl_data[g];
        if (i < 6) cnt[g]++;
      end
      prev_xfer = exp_xfer;
      step();
    end
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("rr_count_r%0d", r), 64'(cnt[r]), 64'd2);
    end

    // Scoreboard: alloc f5, then LSU writes f5
    drive(3'b000, 1'b1, 5'd5, 1'b0);
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    #3;
    chk("sb_alloc_busy5", 64'(busy[5]), 64'h1);
    step();
    set_req(1, 5'd5, 64'h5555);
    drive(3'b010, 1'b0, 5'd0, 1'b0);
    #3;
    chk("sb_lsu_ready", 64'(req_ready), 64'h2);
`ifndef SY_FP_WB_REG_EN
    chk("sb_wr_en", 64'(rdst_en), 64'h1);
    chk("sb_wr_idx", 64'(rdst_idx), 64'd5);
`endif
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    #3;
`ifdef SY_FP_WB_REG_EN
    chk("sb_wr_en", 64'(rdst_en), 64'h1);
    chk("sb_wr_idx", 64'(rdst_idx), 64'd5);
    chk("sb_busy5_held", 64'(busy[5]), 64'h1);
    step();
    #3;
`endif
    chk("sb_busy5_cleared", 64'(busy[5]), 64'h0);
    step();

    // Collision: alloc f7 in the very cycle its write issues
    drive(3'b000, 1'b1, 5'd7, 1'b0);
    step();
    set_req(0, 5'd7, 64'h7777);
`ifdef SY_FP_WB_REG_EN
    drive(3'b001, 1'b0, 5'd0, 1'b0);
    step();
    drive(3'b000, 1'b1, 5'd7, 1'b0);
`else
    drive(3'b001, 1'b1, 5'd7, 1'b0);
`endif
    #3;
    chk("col_wr_en", 64'(rdst_en), 64'h1);
    chk("col_wr_idx", 64'(rdst_idx), 64'd7);
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    #3;
    chk("col_busy7_set_wins", 64'(busy[7]), 64'h1);
    drive(3'b001, 1'b0, 5'd0, 1'b0);
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    step();
    #3;
    chk("col_busy7_later_clear", 64'(busy[7]), 64'h0);
    step();

    // Flush with busy=0xF0 and a request just accepted
    for (int f = 4; f < 8; f++) begin
      drive(3'b000, 1'b1, 5'(f), 1'b0);
      step();
    end
    set_req(0, 5'd20, 64'h9999);
    set_req(1, 5'd21, 64'hAAAA);
    drive(3'b001, 1'b0, 5'd0, 1'b0);
    #3;
    chk("fl_busy_before", 64'(busy), 64'h0000_00F0);
    chk("fl_accept_ready", 64'(req_ready), 64'h1);
    step();
    drive(3'b010, 1'b1, 5'd9, 1'b1);
    #3;
    chk("fl_ready_zero", 64'(req_ready), 64'h0);
    chk("fl_rdst_en_zero", 64'(rdst_en), 64'h0);
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    #3;
    chk("fl_busy_cleared", 64'(busy), 64'h0);
    step();

    // Latency: single FPU-move write of f3
    set_req(2, 5'd3, 64'hDEAD_BEEF);
    drive(3'b100, 1'b0, 5'd0, 1'b0);
    #3;
`ifdef SY_FP_WB_REG_EN
    chk("lat_t0_en", 64'(rdst_en), 64'h0);
`else
    chk("lat_t0_en", 64'(rdst_en), 64'h1);
    chk("lat_t0_idx", 64'(rdst_idx), 64'd3);
    chk("lat_t0_data", rdst_data, 64'hDEAD_BEEF);
`endif
    step();
    drive(3'b000, 1'b0, 5'd0, 1'b0);
    #3;
`ifdef SY_FP_WB_REG_EN
    chk("lat_t1_en", 64'(rdst_en), 64'h1);
    chk("lat_t1_idx", 64'(rdst_idx), 64'd3);
    chk("lat_t1_data", rdst_data, 64'hDEAD_BEEF);
`else
    chk("lat_t1_en", 64'(rdst_en), 64'h0);
    chk("lat_t1_idx", 64'(rdst_idx), 64'd0);
    chk("lat_t1_data", rdst_data, 64'h0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
